video_crop_framer: RTL and testbench
====================================

Name: video_crop_framer

Overview:
- Upstream stage of the maze path-finder pipeline; sits between the camera/decoder pixel stream and the maze-solving video block.
- Takes raw sync-delimited 8-bit luma and crops it to the fixed 702x288 active window.
- Regenerates video_frame_valid / video_line_valid / video_data_valid and the packed video_address the downstream block expects.
- Also publishes a binarization threshold and per-frame stream-integrity flags.

Parameters:
- H_START, 10'd16: first in_de pixel index of a line that is kept.
- H_ACTIVE, 10'd702: kept pixels per line.
- V_START, 9'd20: first line after vsync that is kept (lines counted on in_hsync rising).
- V_ACTIVE, 9'd288: kept lines per frame.
- THRESH_DEFAULT, 8'd50: threshold driven when auto-threshold is compiled out.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- in_vsync  in  1  frame sync, rising edge = new frame
- in_hsync  in  1  line sync, rising edge = new line
- in_de  in  1  input pixel valid
- in_data  in  8  input luma
- video_frame_valid  out  1  high for the whole cropped frame
- video_line_valid  out  1  high for a cropped line
- video_data_valid  out  1  cropped pixel strobe
- video_data  out  8  cropped pixel
- video_address  out  20  [19:11] = row 0..287, [10] = 0, [9:0] = column 0..701
- bin_threshold  out  8  threshold for downstream binarization
- frame_count  out  8  completed cropped frames, wraps 255->0
- short_line_err  out  1  a kept line had fewer than H_ACTIVE pixels (current frame)
- short_frame_err  out  1  vsync arrived before V_ACTIVE lines were emitted

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0, except bin_threshold = THRESH_DEFAULT.
  - FSM goes to WAIT_VSYNC, so a partial frame is never emitted after reset.
- Input sync edges are detected with one registered copy of in_vsync / in_hsync.
- Latency: all video_* outputs are registered, one cycle after the corresponding in_de/in_data.
- Counters: in_line (9b, since vsync), in_pix (10b, in_de count since hsync), out_row (9b), out_col (10b).
- FSM states:
  - WAIT_VSYNC -> VBLANK on vsync rise.
  - VBLANK: count hsync rises; -> ACTIVE when in_line reaches V_START; in_line, out_row cleared.
  - ACTIVE, per line: line_open is set when in_de is high with in_pix == H_START. It clears after H_ACTIVE kept pixels or on the next hsync, whichever comes first.
  - ACTIVE, per pixel: video_data_valid = line_open & in_de; video_line_valid = line_open; out_col increments per kept pixel; out_row increments when a line closes.
  - ACTIVE -> DONE when out_row reaches V_ACTIVE. frame_count increments on this transition.
  - DONE -> VBLANK on vsync rise.
- video_frame_valid:
  - Set with the first video_line_valid of row 0.
  - Cleared the cycle after ACTIVE->DONE, or on a vsync rise.
  - Always at least one low cycle between frames.
- Pixels beyond H_ACTIVE and lines beyond V_ACTIVE are dropped.
- Boundary cases:
  - Line closes by hsync with out_col < H_ACTIVE: short_line_err = 1; the row still counts.
  - vsync rise while in ACTIVE: short_frame_err = 1, frame_valid drops, go to VBLANK; frame_count does not increment.
  - vsync mid-line: line aborted the same cycle; treated as the short-frame case.
  - Error flags clear on entry to ACTIVE, then stay sticky until the next frame.
  - hsync and vsync rising in the same cycle: vsync wins.
- video_address is held at its last value when data_valid = 0; it is zero after reset.

Optional Feature:
- Macro: AUTO_THRESHOLD_EN.
- Defined:
  - Track min and max of kept pixels per frame; both are reset at ACTIVE entry.
  - At ACTIVE->DONE, latch bin_threshold = (min + max) >> 1, computed in 9-bit arithmetic.
  - Aborted (short) frames do not update bin_threshold.
- Undefined: bin_threshold is constant THRESH_DEFAULT; no min/max logic is synthesized.

Decomposition:
- Shared package video_pkg:
  - Constants H_ACTIVE_DEF = 702, V_ACTIVE_DEF = 288.
  - Address field positions ROW_MSB = 19, ROW_LSB = 11, COL_MSB = 9.
  - FSM state encoding: WAIT_VSYNC, VBLANK, ACTIVE, DONE.
- One natural sub-module: sync_edge_det, the registered rising-edge detector, instantiated for vsync and hsync.

Test Plan:
1. Reset released mid-frame (in_line = 100) -> no video_frame_valid until the next vsync. Then exactly 288 lines x 702 data_valid strobes; last address = {9'd287, 1'b0, 10'd701}; frame_count = 1.
2. Input line of 800 pixels with H_START = 16 -> kept pixel 0 equals input pixel 16; column 701 equals input pixel 717; pixels 718..799 are not strobed.
3. One kept line of only 500 pixels -> short_line_err = 1 from that line until the next ACTIVE entry; rows still reach 287; frame_count increments.
4. vsync after 150 kept lines -> short_frame_err = 1; frame_valid low the next cycle; frame_count unchanged; the next frame starts cleanly at row 0.
5. AUTO_THRESHOLD_EN, frame whose pixels span 20..220 -> bin_threshold = 120 after ACTIVE->DONE. Without the macro -> bin_threshold = 50 throughout.
6. 256 complete frames -> frame_count wraps to 0; frame_valid is low for at least 1 cycle between consecutive frames.

Source files
------------

// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_pkg : shared constants and FSM encoding for video_crop_framer   |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package video_pkg;

  localparam int H_ACTIVE_DEF = 702;
  localparam int V_ACTIVE_DEF = 288;

  // Packed video_address layout: {row, 1'b0, col}
  localparam int ROW_MSB = 19;
  localparam int ROW_LSB = 11;
  localparam int COL_MSB = 9;

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    VBLANK     = 2'd1,
    ACTIVE     = 2'd2,
    DONE       = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/video_crop_framer_sync_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_edge_det : rising-edge detector against one registered copy     |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_d;
  logic sig_q;

  always_comb begin
    sig_d = sig;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign rise = sig & ~sig_q;

endmodule
`default_nettype wire

// File: rtl/video_crop_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_crop_framer : crops sync-delimited luma to a fixed window and   |
// | regenerates frame/line/data valids plus packed address. Optional      |
// | macro AUTO_THRESHOLD_EN enables per-frame (min+max)/2 threshold.      |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module video_crop_framer
  import video_pkg::*;
#(
  parameter logic [9:0] H_START        = 10'd16,
  parameter logic [9:0] H_ACTIVE       = 10'(H_ACTIVE_DEF),
  parameter logic [8:0] V_START        = 9'd20,
  parameter logic [8:0] V_ACTIVE       = 9'(V_ACTIVE_DEF),
  parameter logic [7:0] THRESH_DEFAULT = 8'd50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_vsync,
  input  logic        in_hsync,
  input  logic        in_de,
  input  logic [7:0]  in_data,
  output logic        video_frame_valid,
  output logic        video_line_valid,
  output logic        video_data_valid,
  output logic [7:0]  video_data,
  output logic [19:0] video_address,
  output logic [7:0]  bin_threshold,
  output logic [7:0]  frame_count,
  output logic        short_line_err,
  output logic        short_frame_err
);

  logic vs_rise;
  logic hs_rise;

  sync_edge_det u_vs_edge (.clk(clk), .reset(reset), .sig(in_vsync), .rise(vs_rise));
  sync_edge_det u_hs_edge (.clk(clk), .reset(reset), .sig(in_hsync), .rise(hs_rise));

  state_t      state_q, state_d;
  logic [8:0]  in_line_q, in_line_d;
  logic [9:0]  in_pix_q, in_pix_d;
  logic [8:0]  out_row_q, out_row_d;
  logic [9:0]  out_col_q, out_col_d;
  logic        line_open_q, line_open_d;
  logic        frame_valid_q, frame_valid_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic        short_line_err_q, short_line_err_d;
  logic        short_frame_err_q, short_frame_err_d;
  logic        line_valid_q, line_valid_d;
  logic        data_valid_q, data_valid_d;
  logic [7:0]  data_q, data_d;
  logic [19:0] addr_q, addr_d;

  logic [9:0]  pix_idx;
  logic        keep;
  logic        row_close;
  logic        act_entry;
  logic        frame_done;

  always_comb begin
    state_d           = state_q;
    in_line_d         = in_line_q;
    out_row_d         = out_row_q;
    out_col_d         = out_col_q;
    line_open_d       = line_open_q;
    frame_valid_d     = frame_valid_q;
    short_line_err_d  = short_line_err_q;
    short_frame_err_d = short_frame_err_q;
    keep              = 1'b0;
    row_close         = 1'b0;
    act_entry         = 1'b0;
    frame_done        = 1'b0;

    // A pixel coinciding with hsync belongs to the new line as index 0
    pix_idx = hs_rise ? 10'd0 : in_pix_q;
    if (hs_rise) begin
      in_pix_d = {9'd0, in_de};
    end else if (in_de && (in_pix_q != 10'h3FF)) begin
      in_pix_d = in_pix_q + 10'd1;
    end else begin
      in_pix_d = in_pix_q;
    end

    case (state_q)
      WAIT_VSYNC: begin
        if (vs_rise) begin
          state_d   = VBLANK;
          in_line_d = 9'd0;
        end
      end
      VBLANK: begin
        if (vs_rise) begin
          in_line_d = 9'd0;
        end else if (hs_rise) begin
          if (in_line_q == V_START) begin
            act_entry   = 1'b1;
            state_d     = ACTIVE;
            in_line_d   = 9'd0;
            out_row_d   = 9'd0;
            out_col_d   = 10'd0;
            line_open_d = 1'b0;
          end else begin
            in_line_d = in_line_q + 9'd1;
          end
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          // vsync wins over everything, including a line in progress
          state_d           = VBLANK;
          in_line_d         = 9'd0;
          line_open_d       = 1'b0;
          out_col_d         = 10'd0;
          frame_valid_d     = 1'b0;
          short_frame_err_d = 1'b1;
        end else begin
          if (hs_rise && line_open_q) begin
            short_line_err_d = 1'b1;
            row_close        = 1'b1;
            line_open_d      = 1'b0;
            out_col_d        = 10'd0;
          end else if (in_de && (line_open_q || (pix_idx == H_START))) begin
            keep = 1'b1;
            if ((out_row_q == 9'd0) && (out_col_q == 10'd0)) begin
              frame_valid_d = 1'b1;
            end
            if (out_col_q == H_ACTIVE - 10'd1) begin
              row_close   = 1'b1;
              line_open_d = 1'b0;
              out_col_d   = 10'd0;
            end else begin
              line_open_d = 1'b1;
              out_col_d   = out_col_q + 10'd1;
            end
          end
          if (row_close) begin
            out_row_d = out_row_q + 9'd1;
            if (out_row_q == V_ACTIVE - 9'd1) begin
              state_d    = DONE;
              frame_done = 1'b1;
            end
          end
        end
      end
      DONE: begin
        frame_valid_d = 1'b0;
        if (vs_rise) begin
          state_d   = VBLANK;
          in_line_d = 9'd0;
        end
      end
      default: state_d = WAIT_VSYNC;
    endcase

    if (act_entry) begin
      short_line_err_d  = 1'b0;
      short_frame_err_d = 1'b0;
    end
    frame_count_d = frame_count_q + {7'd0, frame_done};

    data_valid_d = keep;
    line_valid_d = keep | line_open_d;
    data_d       = data_q;
    addr_d       = addr_q;
    if (keep) begin
      data_d                  = in_data;
      addr_d                  = '0;
      addr_d[ROW_MSB:ROW_LSB] = out_row_q;
      addr_d[COL_MSB:0]       = out_col_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= WAIT_VSYNC;
      in_line_q         <= 9'd0;
      in_pix_q          <= 10'd0;
      out_row_q         <= 9'd0;
      out_col_q         <= 10'd0;
      line_open_q       <= 1'b0;
      frame_valid_q     <= 1'b0;
      frame_count_q     <= 8'd0;
      short_line_err_q  <= 1'b0;
      short_frame_err_q <= 1'b0;
      line_valid_q      <= 1'b0;
      data_valid_q      <= 1'b0;
      data_q            <= 8'd0;
      addr_q            <= 20'd0;
    end else begin
      state_q           <= state_d;
      in_line_q         <= in_line_d;
      in_pix_q          <= in_pix_d;
      out_row_q         <= out_row_d;
      out_col_q         <= out_col_d;
      line_open_q       <= line_open_d;
      frame_valid_q     <= frame_valid_d;
      frame_count_q     <= frame_count_d;
      short_line_err_q  <= short_line_err_d;
      short_frame_err_q <= short_frame_err_d;
      line_valid_q      <= line_valid_d;
      data_valid_q      <= data_valid_d;
      data_q            <= data_d;
      addr_q            <= addr_d;
    end
  end

`ifdef AUTO_THRESHOLD_EN
  logic [7:0] min_q, min_d;
  logic [7:0] max_q, max_d;
  logic [7:0] thr_q, thr_d;
  logic [8:0] span_sum;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    thr_d = thr_q;
    if (keep) begin
      if (in_data < min_q) min_d = in_data;
      if (in_data > max_q) max_d = in_data;
    end
    // Includes the closing pixel of the frame, hence computed from the _d values
    span_sum = {1'b0, min_d} + {1'b0, max_d};
    if (frame_done) thr_d = span_sum[8:1];
    if (act_entry) begin
      min_d = 8'hFF;
      max_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_q <= 8'hFF;
      max_q <= 8'h00;
      thr_q <= THRESH_DEFAULT;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      thr_q <= thr_d;
    end
  end

  assign bin_threshold = thr_q;
`else
  assign bin_threshold = THRESH_DEFAULT;
`endif

  assign video_frame_valid = frame_valid_q;
  assign video_line_valid  = line_valid_q;
  assign video_data_valid  = data_valid_q;
  assign video_data        = data_q;
  assign video_address     = addr_q;
  assign frame_count       = frame_count_q;
  assign short_line_err    = short_line_err_q;
  assign short_frame_err   = short_frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_video_crop_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_video_crop_framer : directed bench on a reduced 6x4 crop window    |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_video_crop_framer;

  localparam logic [9:0] TB_H_START  = 10'd3;
  localparam logic [9:0] TB_H_ACTIVE = 10'd6;
  localparam logic [8:0] TB_V_START  = 9'd2;
  localparam logic [8:0] TB_V_ACTIVE = 9'd4;

`ifdef AUTO_THRESHOLD_EN
  localparam logic [7:0] THR_A = 8'd29;   // kept span 3..56
  localparam logic [7:0] THR_B = 8'd120;  // kept span 20..220
`else
  localparam logic [7:0] THR_A = 8'd50;
  localparam logic [7:0] THR_B = 8'd50;
`endif

  logic        clk;
  logic        reset;
  logic        in_vsync;
  logic        in_hsync;
  logic        in_de;
  logic [7:0]  in_data;
  logic        video_frame_valid;
  logic        video_line_valid;
  logic        video_data_valid;
  logic [7:0]  video_data;
  logic [19:0] video_address;
  logic [7:0]  bin_threshold;
  logic [7:0]  frame_count;
  logic        short_line_err;
  logic        short_frame_err;

  video_crop_framer #(
    .H_START        (TB_H_START),
    .H_ACTIVE       (TB_H_ACTIVE),
    .V_START        (TB_V_START),
    .V_ACTIVE       (TB_V_ACTIVE),
    .THRESH_DEFAULT (8'd50)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_vsync          (in_vsync),
    .in_hsync          (in_hsync),
    .in_de             (in_de),
    .in_data           (in_data),
    .video_frame_valid (video_frame_valid),
    .video_line_valid  (video_line_valid),
    .video_data_valid  (video_data_valid),
    .video_data        (video_data),
    .video_address     (video_address),
    .bin_threshold     (bin_threshold),
    .frame_count       (frame_count),
    .short_line_err    (short_line_err),
    .short_frame_err   (short_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Output monitor: accumulates strobes, captures pixels by address
  int          n_dv     = 0;
  int          bad_dv   = 0;
  int          fv_rises = 0;
  int          low_run  = 0;
  int          min_gap  = 1000000;
  logic        fv_prev  = 1'b0;
  logic        fv_seen  = 1'b0;
  logic [19:0] last_addr = 20'd0;
  logic [7:0]  cap_data [4][6];

  always @(negedge clk) begin
    if (video_data_valid) begin
      n_dv      <= n_dv + 1;
      last_addr <= video_address;
      if (!video_frame_valid) bad_dv <= bad_dv + 1;
      if ((video_address[19:11] < 9'd4) && (video_address[9:0] < 10'd6))
        cap_data[int'(video_address[12:11])][int'(video_address[2:0])] <= video_data;
    end
    if (video_frame_valid && !fv_prev) begin
      fv_rises <= fv_rises + 1;
      if (fv_seen && (low_run < min_gap)) min_gap <= low_run;
      fv_seen <= 1'b1;
    end
    low_run <= video_frame_valid ? 0 : low_run + 1;
    fv_prev <= video_frame_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // data of input pixel i = base + i*step
  task automatic send_line(input int npix, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] d;
    in_hsync = 1'b1;
    cyc(2);
    in_hsync = 1'b0;
    cyc(1);
    d = base;
    for (int i = 0; i < npix; i++) begin
      in_de   = 1'b1;
      in_data = d;
      cyc(1);
      d = d + step;
    end
    in_de   = 1'b0;
    in_data = 8'd0;
    cyc(2);
  endtask

  task automatic send_kept(input int row, input int npix, input bit thr);
    if (thr) send_line(npix, 8'd156, 8'd40);
    else     send_line(npix, 8'(row * 16), 8'd1);
  endtask

  task automatic vsync_pulse();
    in_vsync = 1'b1;
    cyc(2);
    in_vsync = 1'b0;
    cyc(1);
  endtask

  task automatic send_body(input bit thr);
    for (int i = 0; i < 2; i++) send_line(10, 8'd0, 8'd1);
    for (int r = 0; r < 4; r++) send_kept(r, 10, thr);
    send_line(10, 8'd0, 8'd1);
  endtask

  int dv0;

  initial begin
    reset    = 1'b0;
    in_vsync = 1'b0;
    in_hsync = 1'b0;
    in_de    = 1'b0;
    in_data  = 8'd0;
    cyc(3);
    check("rst_fv",   video_frame_valid, 0);
    check("rst_lv",   video_line_valid, 0);
    check("rst_dv",   video_data_valid, 0);
    check("rst_addr", video_address, 0);
    check("rst_fc",   frame_count, 0);
    check("rst_sle",  short_line_err, 0);
    check("rst_sfe",  short_frame_err, 0);
    check("rst_thr",  bin_threshold, 50);
    reset = 1'b1;
    cyc(1);

    // Lines with no vsync seen yet: nothing may be emitted
    for (int i = 0; i < 5; i++) send_line(10, 8'd0, 8'd1);
    check("pre_fv_rises", fv_rises, 0);
    check("pre_dv", n_dv, 0);

    // Frame 1: 10-pixel lines, pixel 9 of each line is beyond the window
    dv0 = n_dv;
    vsync_pulse();
    send_body(1'b0);
    check("f1_dv",     n_dv - dv0, 24);
    check("f1_addr",   last_addr, {9'd3, 1'b0, 10'd5});
    check("f1_fc",     frame_count, 1);
    check("f1_r0c0",   cap_data[0][0], 3);
    check("f1_r0c5",   cap_data[0][5], 8);
    check("f1_r3c5",   cap_data[3][5], 56);
    check("f1_fv_off", video_frame_valid, 0);
    check("f1_thr",    bin_threshold, THR_A);
    check("f1_errs",   {short_line_err, short_frame_err}, 0);

    // Frame 2: row 1 carries only 3 kept pixels
    dv0 = n_dv;
    vsync_pulse();
    for (int i = 0; i < 2; i++) send_line(10, 8'd0, 8'd1);
    send_kept(0, 10, 1'b0);
    send_kept(1, 6, 1'b0);
    check("f2_sle_open", short_line_err, 0);
    send_kept(2, 10, 1'b0);
    check("f2_sle_set", short_line_err, 1);
    send_kept(3, 10, 1'b0);
    send_line(10, 8'd0, 8'd1);
    check("f2_dv",   n_dv - dv0, 21);
    check("f2_addr", last_addr, {9'd3, 1'b0, 10'd5});
    check("f2_fc",   frame_count, 2);
    check("f2_r1c2", cap_data[1][2], 21);
    check("f2_r2c0", cap_data[2][0], 35);
    check("f2_sle",  short_line_err, 1);

    // Aborted frame: vsync after two kept rows
    vsync_pulse();
    for (int i = 0; i < 2; i++) send_line(10, 8'd0, 8'd1);
    send_kept(0, 10, 1'b1);
    check("ab_sle_clr", short_line_err, 0);
    send_kept(1, 10, 1'b1);
    check("ab_fv_on", video_frame_valid, 1);
    in_vsync = 1'b1;
    cyc(1);
    check("ab_fv_off", video_frame_valid, 0);
    check("ab_sfe",    short_frame_err, 1);
    check("ab_fc",     frame_count, 2);
    cyc(1);
    in_vsync = 1'b0;
    cyc(1);
    check("ab_thr", bin_threshold, THR_A);

    // The abort vsync starts the next frame
    dv0 = n_dv;
    send_body(1'b0);
    check("f3_dv",   n_dv - dv0, 24);
    check("f3_r0c0", cap_data[0][0], 3);
    check("f3_fc",   frame_count, 3);
    check("f3_sfe",  short_frame_err, 0);

    // Kept pixels span 20..220
    vsync_pulse();
    send_body(1'b1);
    check("thr_fc",  frame_count, 4);
    check("thr_val", bin_threshold, THR_B);

    for (int f = 0; f < 252; f++) begin
      vsync_pulse();
      send_body(1'b0);
    end
    check("wrap_fc",  frame_count, 0);
    check("fv_rises", fv_rises, 257);
    check("fv_gap",   32'(min_gap >= 1), 1);
    check("bad_dv",   bad_dv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
